instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Fetch/execute sequencer for the 9-bit CPU.
- Owns the program counter and a hardware return-address stack.
- Steps the instruction decoder through FETCH/EXEC and stalls on data-memory loads/stores.
- Converts the decoder's start/done, branch, call (funcEn) and return (rFsr) indications into PC updates and register-commit strobes.

Parameters:
- PC_W, 10, program counter width in bits
- STACK_D, 4, return-address stack depth (entries)
- TMO_CYC, 15, MEM_WAIT timeout in cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; begins execution from PC 0 when in IDLE or HALT
- done  in  1  decoder halt indication (valid while instr_valid=1)
- mem_req  in  1  decoder loadEn|storEn for the current instruction
- mem_ack  in  1  data memory completion, single-cycle pulse
- branch_take  in  1  resolved branch/jump taken for the current instruction
- call  in  1  current instruction is a function call
- ret  in  1  current instruction is a return
- branch_tgt  in  PC_W  target address for a taken branch or a call
- pc  out  PC_W  instruction memory address
- fetch_en  out  1  instruction memory read enable (synchronous read, 1-cycle latency)
- instr_valid  out  1  instruction register holds a valid instruction for the decoder
- exec_en  out  1  commit strobe to the register file, ALU and flags
- busy  out  1  high in FETCH, EXEC and MEM_WAIT
- halted  out  1  high in HALT
- stack_err  out  1  sticky flag; stack overflow or underflow occurred

Behaviour:
- Reset (async, immediate): state=IDLE, pc=0, sp=0, stack_err=0, and every other output 0. Reset mid-instruction discards the pending commit and any stack push.
- States and output decode:
  - IDLE: busy=0.
  - FETCH: fetch_en=1. Next state is always EXEC.
  - EXEC: instr_valid=1. Resolves in this priority order, highest first:
    1. done → HALT, pc held, exec_en=0.
    2. mem_req → MEM_WAIT, exec_en=0, pc held.
    3. ret → if sp==0: stack_err=1, go to HALT. Else pc=stack[sp-1], sp-=1, exec_en=1, go to FETCH.
    4. call → if sp==STACK_D: stack_err=1, go to HALT. Else stack[sp]=pc+1, sp+=1, pc=branch_tgt, exec_en=1, go to FETCH.
    5. branch_take → pc=branch_tgt, exec_en=1, go to FETCH.
    6. Otherwise → pc=pc+1, exec_en=1, go to FETCH.
  - MEM_WAIT: instr_valid=1, exec_en=0 until mem_ack. On the mem_ack cycle: exec_en=1, pc=pc+1, next state FETCH. call, ret and branch_take are ignored in this state.
  - HALT: halted=1, pc frozen, stack_err held.
- Transitions out of idle/halt: from IDLE or HALT, start=1 → FETCH with pc=0, sp=0, stack_err=0. start is ignored while busy=1.
- Instruction timing: minimum 2 cycles per instruction; loads/stores take 3 + (ack delay) cycles.
- PC arithmetic is modulo 2^PC_W; pc+1 at all-ones wraps to 0. The stored return address wraps the same way.
- mem_ack outside MEM_WAIT is ignored.
- A taken branch and a call together: call wins; branch_tgt is used once.
- Stack contents are not cleared on start; only sp is reset.

Optional Feature:
- Macro: SEQ_MEM_TIMEOUT_EN.
- Defined:
  - A counter runs in MEM_WAIT.
  - If TMO_CYC cycles pass without mem_ack, the block enters HALT with stack_err unchanged and asserts extra output mem_tmo (sticky). mem_tmo is cleared on start or reset.
  - mem_ack arriving on the same cycle as the timeout wins, giving normal completion.
- Undefined: no counter and no mem_tmo port; MEM_WAIT waits indefinitely.

Test Plan:
- Reset then start=1 for one cycle, decoder supplies plain ops → pc sequence 0,1,2,3; fetch_en and exec_en alternate each cycle; busy=1.
- EXEC at pc=5 with branch_take=1, branch_tgt=40 → next FETCH at pc=40, exec_en=1 for one cycle; with done=1 also asserted → HALT, pc=5, no commit.
- Load at pc=7, mem_ack 3 cycles after entering MEM_WAIT → exec_en pulses exactly once on the ack cycle, pc=8, instruction takes 6 cycles.
- call at pc=10 to 100, then ret at 100 → pc 100 then 11, sp returns to 0. Five nested calls with STACK_D=4 → stack_err=1, halted=1, pc held at fifth call site.
- ret with sp=0 → stack_err=1, HALT; then start=1 → pc=0, stack_err=0, running. Assert rst_n=0 during MEM_WAIT → outputs 0 immediately, state IDLE.
- PC_W=4, run to pc=15 with plain op → pc wraps to 0. With SEQ_MEM_TIMEOUT_EN and no mem_ack → HALT after 15 cycles, mem_tmo=1.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the 9-bit CPU.
// It owns the program counter and the hardware return-address stack. It steps
// the decoder through FETCH/EXEC, stalls in MEM_WAIT for data-memory loads and
// stores, and turns the decoder's start/done, branch, call and return
// indications into PC updates and register-commit strobes.
//
// Optional build macro SEQ_MEM_TIMEOUT_EN: adds a MEM_WAIT watchdog. After
// TMO_CYC cycles without mem_ack, the block halts and raises the sticky
// output mem_tmo.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | out of reset, waiting for start
// FETCH    | instruction memory read issued at pc
// EXEC     | instruction register valid, decoder resolves next pc
// MEM_WAIT | load/store in flight, commit held until mem_ack
// HALT     | stopped by done or a stack error, waiting for start

module instr_sequencer #(
    parameter int PC_W    = 10,
    parameter int STACK_D = 4,
    parameter int TMO_CYC = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            done,
    input  logic            mem_req,
    input  logic            mem_ack,
    input  logic            branch_take,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] branch_tgt,
    output logic [PC_W-1:0] pc,
    output logic            fetch_en,
    output logic            instr_valid,
    output logic            exec_en,
    output logic            busy,
    output logic            halted,
`ifdef SEQ_MEM_TIMEOUT_EN
    output logic            stack_err,
    output logic            mem_tmo
`else
    output logic            stack_err
`endif
);

    // sp has to represent STACK_D itself (full stack), so it is one value wider than an index.
    localparam int SP_W  = $clog2(STACK_D + 1);
    localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [PC_W-1:0]   pc_inc;
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_nxt;
    logic [SP_W-1:0]   sp_dec;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              err_nxt;
    logic              push_en;
    logic [PC_W-1:0]   stack_mem [STACK_D];

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_nxt;
`else
    // TMO_CYC only matters when the watchdog is built in.
    logic              unused_tmo_cfg;
    assign unused_tmo_cfg = ^TMO_CYC;
`endif

    // Both wrap modulo 2^PC_W. That includes the return address pushed at the all-ones pc.
    assign pc_inc = pc + PC_W'(1);
    assign sp_dec = sp - SP_W'(1);
    assign wr_idx = sp[IDX_W-1:0];
    assign rd_idx = sp_dec[IDX_W-1:0];

    // Next-state, PC/stack update and output decode.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        sp_nxt      = sp;
        err_nxt     = stack_err;
        push_en     = 1'b0;
        fetch_en    = 1'b0;
        instr_valid = 1'b0;
        exec_en     = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
`ifdef SEQ_MEM_TIMEOUT_EN
        tmo_nxt     = mem_tmo;
`endif
        case (state)
            S_IDLE, S_HALT: begin
                halted = (state == S_HALT);
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                    sp_nxt    = '0;
                    err_nxt   = 1'b0;
`ifdef SEQ_MEM_TIMEOUT_EN
                    tmo_nxt   = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                fetch_en  = 1'b1;
                busy      = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                busy        = 1'b1;
                if (done) begin
                    state_nxt = S_HALT;
                end else if (mem_req) begin
                    state_nxt = S_MEM_WAIT;
                end else if (ret) begin
                    if (sp == '0) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_HALT;
                    end else begin
                        pc_nxt    = stack_mem[rd_idx];
                        sp_nxt    = sp_dec;
                        exec_en   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else if (call) begin
                    if (sp == SP_W'(STACK_D)) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_HALT;
                    end else begin
                        push_en   = 1'b1;
                        sp_nxt    = sp + SP_W'(1);
                        pc_nxt    = branch_tgt;
                        exec_en   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else if (branch_take) begin
                    pc_nxt    = branch_tgt;
                    exec_en   = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    pc_nxt    = pc_inc;
                    exec_en   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_MEM_WAIT: begin
                instr_valid = 1'b1;
                busy        = 1'b1;
                if (mem_ack) begin
                    pc_nxt    = pc_inc;
                    exec_en   = 1'b1;
                    state_nxt = S_FETCH;
`ifdef SEQ_MEM_TIMEOUT_EN
                end else if (tmo_cnt == '0) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = S_HALT;
`endif
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, pc, stack pointer and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            sp        <= '0;
            stack_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            sp        <= sp_nxt;
            stack_err <= err_nxt;
        end
    end

    // Return-address storage. It is left uncleared because only sp defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[wr_idx] <= pc_inc;
        end
    end

`ifdef SEQ_MEM_TIMEOUT_EN
    // Watchdog down-counter. It is loaded on entry to MEM_WAIT and times out at terminal count zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            mem_tmo <= 1'b0;
        end else begin
            mem_tmo <= tmo_nxt;
            if (state == S_EXEC && state_nxt == S_MEM_WAIT) begin
                tmo_cnt <= TMO_W'(TMO_CYC - 1);
            end else if (state == S_MEM_WAIT && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - TMO_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer. The bench acts as the decoder: for each
// cycle it drives the decoder inputs on the falling edge and checks the
// outputs 1 ns later against hand-computed values.
module tb_instr_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       done;
    logic       mem_req;
    logic       mem_ack;
    logic       branch_take;
    logic       call;
    logic       ret;
    logic [9:0] branch_tgt;
    logic [9:0] pc;
    logic       fetch_en;
    logic       instr_valid;
    logic       exec_en;
    logic       busy;
    logic       halted;
    logic       stack_err;
`ifdef SEQ_MEM_TIMEOUT_EN
    logic       mem_tmo;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    instr_sequencer #(.PC_W(10), .STACK_D(4), .TMO_CYC(15)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .done        (done),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .branch_take (branch_take),
        .call        (call),
        .ret         (ret),
        .branch_tgt  (branch_tgt),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .instr_valid (instr_valid),
        .exec_en     (exec_en),
        .busy        (busy),
        .halted      (halted),
`ifdef SEQ_MEM_TIMEOUT_EN
        .stack_err   (stack_err),
        .mem_tmo     (mem_tmo)
`else
        .stack_err   (stack_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic d, input logic mr, input logic ma,
                         input logic bt, input logic cl, input logic rt, input logic [9:0] tgt);
        start       = s;
        done        = d;
        mem_req     = mr;
        mem_ack     = ma;
        branch_take = bt;
        call        = cl;
        ret         = rt;
        branch_tgt  = tgt;
    endtask

    task automatic fetch_cyc(input logic [9:0] exp_pc);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 10'd0);
        #1;
        check("fetch_en", 32'(fetch_en), 1);
        check("fetch_pc", 32'(pc), 32'(exp_pc));
        check("fetch_exec_en", 32'(exec_en), 0);
        check("fetch_busy", 32'(busy), 1);
    endtask

    task automatic exec_cyc(input logic d, input logic mr, input logic ma, input logic bt,
                            input logic cl, input logic rt, input logic [9:0] tgt,
                            input logic exp_exec, input logic [9:0] exp_pc);
        @(negedge clk);
        drive(0, d, mr, ma, bt, cl, rt, tgt);
        #1;
        check("exec_valid", 32'(instr_valid), 1);
        check("exec_en", 32'(exec_en), 32'(exp_exec));
        check("exec_pc", 32'(pc), 32'(exp_pc));
    endtask

    // Applies start while idle/halted. Expects the given halted level and pc before the restart.
    task automatic restart(input logic exp_halted, input logic [9:0] exp_pc);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 10'd0);
        #1;
        check("idle_halted", 32'(halted), 32'(exp_halted));
        check("idle_busy", 32'(busy), 0);
        check("idle_pc", 32'(pc), 32'(exp_pc));
        fetch_cyc(10'd0);
        check("restart_err", 32'(stack_err), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 10'd0);
        #3;
        check("rst_pc", 32'(pc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fetch", 32'(fetch_en), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_err", 32'(stack_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain ops run pc 0..3 and alternate FETCH/EXEC.
        restart(0, 10'd0);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) fetch_cyc(10'(i));
            exec_cyc(0, 0, 0, 0, 0, 0, 10'd0, 1, 10'(i));
        end
        fetch_cyc(10'd4);
        exec_cyc(0, 0, 0, 0, 0, 0, 10'd0, 1, 10'd4);

        // Branch at pc 5 to 40.
        fetch_cyc(10'd5);
        exec_cyc(0, 0, 0, 1, 0, 0, 10'd40, 1, 10'd5);
        fetch_cyc(10'd40);
        // start is ignored while busy.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 10'd0);
        #1;
        check("busy_start_exec", 32'(exec_en), 1);
        fetch_cyc(10'd41);
        // done together with branch at pc 5 halts with no commit.
        exec_cyc(0, 0, 0, 1, 0, 0, 10'd5, 1, 10'd41);
        fetch_cyc(10'd5);
        exec_cyc(1, 0, 0, 1, 0, 0, 10'd40, 0, 10'd5);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0, 0, 10'd0);
        #1;
        check("done_halted", 32'(halted), 1);
        check("done_pc", 32'(pc), 5);
        check("done_exec_en", 32'(exec_en), 0);

        // Load at pc 7, acked on the fourth MEM_WAIT cycle.
        restart(1, 10'd5);
        exec_cyc(0, 0, 0, 1, 0, 0, 10'd7, 1, 10'd0);
        fetch_cyc(10'd7);
        exec_cyc(0, 1, 0, 0, 0, 0, 10'd0, 0, 10'd7);
        exec_cyc(0, 0, 0, 1, 1, 1, 10'd99, 0, 10'd7);
        exec_cyc(0, 0, 0, 0, 0, 0, 10'd0, 0, 10'd7);
        exec_cyc(0, 0, 0, 0, 0, 0, 10'd0, 0, 10'd7);
        exec_cyc(0, 0, 1, 0, 0, 0, 10'd0, 1, 10'd7);
        fetch_cyc(10'd8);

        // Call at pc 10 to 100 with a branch also taken, then ret.
        exec_cyc(0, 0, 0, 1, 0, 0, 10'd10, 1, 10'd8);
        fetch_cyc(10'd10);
        exec_cyc(0, 0, 0, 1, 1, 0, 10'd100, 1, 10'd10);
        fetch_cyc(10'd100);
        check("call_sp", 32'(u_dut.sp), 1);
        exec_cyc(0, 0, 0, 0, 0, 1, 10'd0, 1, 10'd100);
        fetch_cyc(10'd11);
        check("ret_sp", 32'(u_dut.sp), 0);

        // Five nested calls overflow the 4-deep stack at pc 500.
        exec_cyc(0, 0, 0, 0, 1, 0, 10'd200, 1, 10'd11);
        fetch_cyc(10'd200);
        exec_cyc(0, 0, 0, 0, 1, 0, 10'd300, 1, 10'd200);
        fetch_cyc(10'd300);
        exec_cyc(0, 0, 0, 0, 1, 0, 10'd400, 1, 10'd300);
        fetch_cyc(10'd400);
        exec_cyc(0, 0, 0, 0, 1, 0, 10'd500, 1, 10'd400);
        fetch_cyc(10'd500);
        check("full_sp", 32'(u_dut.sp), 4);
        exec_cyc(0, 0, 0, 0, 1, 0, 10'd600, 0, 10'd500);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 10'd0);
        #1;
        check("ovf_halted", 32'(halted), 1);
        check("ovf_err", 32'(stack_err), 1);
        check("ovf_pc", 32'(pc), 500);

        // ret with an empty stack.
        restart(1, 10'd500);
        exec_cyc(0, 0, 0, 0, 0, 1, 10'd0, 0, 10'd0);
        @(negedge clk);
        #1;
        check("unf_halted", 32'(halted), 1);
        check("unf_err", 32'(stack_err), 1);

        // pc wrap at 1023, and a return address pushed at 1023 wraps to 0.
        restart(1, 10'd0);
        exec_cyc(0, 0, 0, 1, 0, 0, 10'd1023, 1, 10'd0);
        fetch_cyc(10'd1023);
        exec_cyc(0, 0, 0, 0, 1, 0, 10'd50, 1, 10'd1023);
        fetch_cyc(10'd50);
        exec_cyc(0, 0, 0, 0, 0, 1, 10'd0, 1, 10'd50);
        fetch_cyc(10'd0);
        exec_cyc(0, 0, 0, 1, 0, 0, 10'd1023, 1, 10'd0);
        fetch_cyc(10'd1023);
        exec_cyc(0, 0, 0, 0, 0, 0, 10'd0, 1, 10'd1023);
        fetch_cyc(10'd0);

`ifdef SEQ_MEM_TIMEOUT_EN
        // No ack: HALT after 15 MEM_WAIT cycles, with mem_tmo set.
        exec_cyc(0, 1, 0, 0, 0, 0, 10'd0, 0, 10'd0);
        for (int i = 0; i < 15; i++) begin
            exec_cyc(0, 0, 0, 0, 0, 0, 10'd0, 0, 10'd0);
        end
        @(negedge clk);
        #1;
        check("tmo_halted", 32'(halted), 1);
        check("tmo_flag", 32'(mem_tmo), 1);
        check("tmo_err", 32'(stack_err), 0);
        restart(1, 10'd0);
        check("tmo_clear", 32'(mem_tmo), 0);
`endif

        // Async reset in the middle of a load.
        exec_cyc(0, 0, 0, 1, 0, 0, 10'd33, 1, 10'd0);
        fetch_cyc(10'd33);
        exec_cyc(0, 1, 0, 0, 0, 0, 10'd0, 0, 10'd33);
        exec_cyc(0, 0, 0, 0, 0, 0, 10'd0, 0, 10'd33);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0, 0, 10'd0);
        rst_n = 1'b0;
        #1;
        check("mrst_pc", 32'(pc), 0);
        check("mrst_valid", 32'(instr_valid), 0);
        check("mrst_exec_en", 32'(exec_en), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_halted", 32'(halted), 0);
        @(negedge clk);
        rst_n = 1'b1;
        restart(0, 10'd0);
        exec_cyc(0, 0, 0, 0, 0, 0, 10'd0, 1, 10'd0);
        fetch_cyc(10'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
